// File: rtl/router_pkt_src.sv
// rtl/router_pkt_src.sv - packet source feeding the router input port
// Buffers a payload, then sends header {len,addr}, payload bytes and a trailing parity byte.
module router_pkt_src #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          start,
   input  logic [1:0]    dest_addr,
   input  logic          corrupt_parity,
   input  logic          busy,
   output logic          pkt_valid,
   output logic [7:0]    dout,
   output logic          tx_active,
   output logic          done,
   output logic          err,
   output logic [AW:0]   level
);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt, rem, fill;
   logic [7:0]    parity, parity_nxt, dout_nxt;
   logic          corrupt;
   logic          wr_ok, pop, launch, reject, done_nxt;

   // Pointers wrap modulo DEPTH, so the difference is the fill level directly.
   assign fill  = wr_ptr - rd_ptr;
   assign level = {1'b0, fill};
   assign wr_ok = (state == IDLE) && wr_en && !start && (fill != AW'(DEPTH - 1));

   always_comb begin
      state_nxt  = state;
      launch     = 1'b0;
      reject     = 1'b0;
      pop        = 1'b0;
      done_nxt   = 1'b0;
      rd_nxt     = rd_ptr;
      parity_nxt = parity;
      dout_nxt   = dout;
      case (state)
         IDLE: begin
            dout_nxt = 8'h00;
            if (start) begin
               if (dest_addr == 2'd3 || fill == '0) begin
                  reject = 1'b1;
               end else begin
                  launch     = 1'b1;
                  state_nxt  = HEADER;
                  dout_nxt   = {fill[5:0], dest_addr};
                  parity_nxt = {fill[5:0], dest_addr};
               end
            end
         end
         HEADER: begin
            if (!busy) begin
               state_nxt = PAYLOAD;
               dout_nxt  = mem[rd_ptr];
            end
         end
         PAYLOAD: begin
            if (!busy) begin
               pop        = 1'b1;
               rd_nxt     = rd_ptr + 1'b1;
               parity_nxt = parity ^ dout;
               if (rem == AW'(1)) begin
                  state_nxt = PARITY;
                  dout_nxt  = parity_nxt ^ {7'b0, corrupt};
               end else begin
                  dout_nxt  = mem[rd_nxt];
               end
            end
         end
         PARITY: begin
            if (!busy) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               dout_nxt  = 8'h00;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rem       <= '0;
         parity    <= 8'h00;
         corrupt   <= 1'b0;
         dout      <= 8'h00;
         pkt_valid <= 1'b0;
         tx_active <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         rd_ptr    <= rd_nxt;
         parity    <= parity_nxt;
         dout      <= dout_nxt;
         pkt_valid <= (state_nxt == HEADER) || (state_nxt == PAYLOAD);
         tx_active <= (state_nxt != IDLE);
         done      <= done_nxt;
         err       <= reject;
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (launch) begin
            rem     <= fill;
            corrupt <= corrupt_parity;
         end else if (pop) begin
            rem     <= rem - 1'b1;
         end
      end
   end

   // Payload storage has no reset; contents are irrelevant until written.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb/tb_router_pkt_src.sv - directed self-checking bench for router_pkt_src
module tb_router_pkt_src;

   logic       clk = 1'b0;
   logic       rst, wr_en, start, corrupt_parity, busy;
   logic [7:0] wr_data;
   logic [1:0] dest_addr;
   logic       pkt_valid, tx_active, done, err;
   logic [7:0] dout;
   logic [6:0] level;

   router_pkt_src dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
      .dest_addr(dest_addr), .corrupt_parity(corrupt_parity), .busy(busy),
      .pkt_valid(pkt_valid), .dout(dout), .tx_active(tx_active), .done(done),
      .err(err), .level(level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, start_cyc = 0;
   int stall_viol = 0, idle_run = 0, min_gap = 1000;
   logic       prev_hold = 1'b0, prev_tx = 1'b0;
   logic [8:0] prev_byte = '0;
   logic [8:0] acc_q[$];
   logic [8:0] exp_q[$];

   // Negedge monitor: logs every byte the router accepts, watches stalls and gaps.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && {pkt_valid, dout} !== prev_byte) stall_viol++;
         prev_hold = tx_active && busy;
         prev_byte = {pkt_valid, dout};
         if (tx_active && !busy) acc_q.push_back({pkt_valid, dout});
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (err) err_cnt++;
         if (tx_active && !prev_tx && idle_run < min_gap) min_gap = idle_run;
         idle_run = tx_active ? 0 : idle_run + 1;
      end
      prev_tx = tx_active;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic go(input logic [1:0] a, input logic c);
      start = 1'b1; dest_addr = a; corrupt_parity = c;
      tick();
      start = 1'b0; corrupt_parity = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(output bit ok);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < 400) begin
         tick();
         n++;
      end
      ok = (done_cnt != d0);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({pkt_valid, tx_active, done, err, dout} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got pv=%b tx=%b done=%b err=%b dout=%h expected all zero",
                  pkt_valid, tx_active, done, err, dout);
      end
      n_checks++;
      if (level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
   endtask

   task automatic test_basic();
      bit ok;
      wr(8'h11); wr(8'h22); wr(8'h33);
      n_checks++;
      if (level !== 7'd3) begin n_fail++; $display("FAIL basic_level_pre: got %0d expected 3", level); end
      acc_q.delete();
      exp_q = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D};
      go(2'd1, 1'b0);
      wait_done(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
      n_checks++;
      if (done_cyc - start_cyc !== 6) begin
         n_fail++; $display("FAIL basic_latency: got %0d expected 6", done_cyc - start_cyc);
      end
      n_checks++;
      if (acc_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL basic_count: got %0d expected %0d", acc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [8:0] g;
         g = (i < acc_q.size()) ? acc_q[i] : 9'hxxx;
         n_checks++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, g, exp_q[i]); end
      end
      n_checks++;
      if (level !== 7'd0) begin n_fail++; $display("FAIL basic_level_post: got %0d expected 0", level); end
   endtask

   task automatic test_stall();
      bit ok;
      wr(8'h11); wr(8'h22); wr(8'h33);
      acc_q.delete();
      stall_viol = 0;
      exp_q = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D};
      go(2'd1, 1'b0);
      busy = 1'b1;
      repeat (3) tick();
      busy = 1'b0;
      tick();
      tick();
      busy = 1'b1;
      repeat (2) tick();
      busy = 1'b0;
      wait_done(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no done expected done"); end
      n_checks++;
      if (done_cyc - start_cyc !== 11) begin
         n_fail++; $display("FAIL stall_latency: got %0d expected 11", done_cyc - start_cyc);
      end
      n_checks++;
      if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", stall_viol); end
      n_checks++;
      if (acc_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL stall_count: got %0d expected %0d", acc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [8:0] g;
         g = (i < acc_q.size()) ? acc_q[i] : 9'hxxx;
         n_checks++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_reject();
      do_reset();
      go(2'd0, 1'b0);
      n_checks++;
      if ({err, tx_active} !== 2'b10) begin
         n_fail++; $display("FAIL reject_empty: got err=%b tx=%b expected err=1 tx=0", err, tx_active);
      end
      tick();
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: got err=%b expected 0", err); end
      wr(8'h77);
      go(2'd3, 1'b0);
      n_checks++;
      if ({err, tx_active} !== 2'b10) begin
         n_fail++; $display("FAIL reject_addr3: got err=%b tx=%b expected err=1 tx=0", err, tx_active);
      end
      n_checks++;
      if (level !== 7'd1) begin n_fail++; $display("FAIL reject_level: got %0d expected 1", level); end
      do_reset();
   endtask

   task automatic test_corrupt();
      bit ok;
      wr(8'hA5);
      acc_q.delete();
      exp_q = '{9'h104, 9'h1A5, 9'h0A0};
      wr_en = 1'b1; wr_data = 8'hFF;
      start = 1'b1; dest_addr = 2'd0; corrupt_parity = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0; corrupt_parity = 1'b0;
      wait_done(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL corrupt_timeout: got no done expected done"); end
      n_checks++;
      if (acc_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL corrupt_count: got %0d expected %0d", acc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [8:0] g;
         g = (i < acc_q.size()) ? acc_q[i] : 9'hxxx;
         n_checks++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL corrupt_byte%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [7:0] par;
      do_reset();
      min_gap = 1000;
      for (int p = 0; p < 2; p++) begin
         int nwr;
         nwr = (p == 0) ? 64 : 63;
         for (int k = 0; k < nwr; k++) wr(8'(p * 63 + k));
         n_checks++;
         if (level !== 7'd63) begin n_fail++; $display("FAIL max%0d_level_full: got %0d expected 63", p, level); end
         exp_q.delete();
         exp_q.push_back(9'h1FE);
         par = 8'hFE;
         for (int k = 0; k < 63; k++) begin
            exp_q.push_back({1'b1, 8'(p * 63 + k)});
            par = par ^ 8'(p * 63 + k);
         end
         exp_q.push_back({1'b0, par});
         acc_q.delete();
         go(2'd2, 1'b0);
         wait_done(ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL max%0d_timeout: got no done expected done", p); end
         n_checks++;
         if (acc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL max%0d_count: got %0d expected %0d", p, acc_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            logic [8:0] g;
            g = (i < acc_q.size()) ? acc_q[i] : 9'hxxx;
            n_checks++;
            if (g !== exp_q[i]) begin n_fail++; $display("FAIL max%0d_byte%0d: got %h expected %h", p, i, g, exp_q[i]); end
         end
         n_checks++;
         if (level !== 7'd0) begin n_fail++; $display("FAIL max%0d_level_post: got %0d expected 0", p, level); end
      end
      n_checks++;
      if (min_gap < 1) begin n_fail++; $display("FAIL max_gap: got %0d idle cycles expected >=1", min_gap); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      for (int k = 0; k < 10; k++) wr(8'(8'h30 + k));
      go(2'd1, 1'b0);
      tick();
      tick();
      n_checks++;
      if ({pkt_valid, dout} !== 9'h131) begin
         n_fail++; $display("FAIL midrst_pre: got pv=%b dout=%h expected pv=1 dout=31", pkt_valid, dout);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({pkt_valid, tx_active, level} !== 9'h000) begin
         n_fail++; $display("FAIL midrst_abort: got pv=%b tx=%b level=%0d expected 0 0 0", pkt_valid, tx_active, level);
      end
      wr(8'hC3); wr(8'h3C);
      acc_q.delete();
      exp_q = '{9'h10A, 9'h1C3, 9'h13C, 9'h0F5};
      go(2'd2, 1'b0);
      wait_done(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL midrst_timeout: got no done expected done"); end
      n_checks++;
      if (acc_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL midrst_count: got %0d expected %0d", acc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [8:0] g;
         g = (i < acc_q.size()) ? acc_q[i] : 9'hxxx;
         n_checks++;
         if (g !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h expected %h", i, g, exp_q[i]); end
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
      dest_addr = 2'd0; corrupt_parity = 1'b0; busy = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_reject();
      test_corrupt();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
